fpu_mm_queued: RTL and testbench

- Second-generation Avalon-MM slave front end for the fixed-point sign-magnitude FPU core.
- Replaces the single operand set and start bit with a command FIFO, a sequencer FSM and a result FIFO, so software can queue up to DEPTH operations without polling between them.
- Operand width is parametrised. Adds overflow/underflow/timeout sticky flags, flush, and a level interrupt.
- Sits between the system interconnect and one FPU core instance; the core attaches through the core_* ports.

---
 rtl/fpu_mm_queued.sv | 233 +++++++++++++++++++++++
 tb/tb_fpu_mm_queued.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mm_queued.sv
// Avalon-MM front end for the sign-magnitude FPU core: command FIFO, a
// sequencer that issues one operation at a time, and a result FIFO.
module fpu_mm_queued #(
  parameter int INT_W       = 8,
  parameter int FRAC_W      = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chipselect,
  input  logic [4:0]                address,
  input  logic                      write,
  input  logic                      read,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic                      core_start,
  output logic [INT_W+FRAC_W:0]     core_a,
  output logic [INT_W+FRAC_W:0]     core_b,
  output logic [1:0]                core_op,
  input  logic                      core_done,
  input  logic [31:0]               core_result
);

  localparam int OP_W  = 1 + INT_W + FRAC_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int CMD_W = 2 * OP_W + 2;
  localparam int TW    = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [4:0] A_OPA    = 5'h00;
  localparam logic [4:0] A_OPB    = 5'h01;
  localparam logic [4:0] A_CMD    = 5'h02;
  localparam logic [4:0] A_RESULT = 5'h03;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] A_CTRL   = 5'h05;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t state, state_nx;

  logic wr_acc, rd_acc;
  logic wr_cmd, wr_ctrl, rd_result, flush;

  logic [OP_W-1:0] opa_stage, opb_stage;
  logic            irq_en, ovf_flag, unf_flag, to_flag;

  logic [CMD_W-1:0] cmd_mem [DEPTH];
  logic [PW-1:0]    cmd_wp, cmd_rp;
  logic [CW-1:0]    cmd_count;
  logic             cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [CMD_W-1:0] cmd_head;

  logic [31:0]      res_mem [DEPTH];
  logic [PW-1:0]    res_wp, res_rp;
  logic [CW-1:0]    res_count;
  logic             res_full, res_empty, res_push, res_pop;
  logic [31:0]      res_head;

  logic             seq_push, to_set, launch, tmo_expire;
  logic [31:0]      seq_data;
  logic [TW-1:0]    tmo_cnt;

  assign wr_acc    = chipselect & write;
  assign rd_acc    = chipselect & read;
  assign wr_cmd    = wr_acc & (address == A_CMD);
  assign wr_ctrl   = wr_acc & (address == A_CTRL);
  assign rd_result = rd_acc & (address == A_RESULT);
  assign flush     = wr_ctrl & writedata[2];

  generate
    if (OP_W < 32) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = ^writedata[31:OP_W];
    end
  endgenerate

  // Command FIFO; a full FIFO drops the push even if the sequencer pops now.
  assign cmd_full  = (cmd_count == CW'(DEPTH));
  assign cmd_empty = (cmd_count == '0);
  assign cmd_push  = wr_cmd & ~cmd_full & ~flush;
  assign cmd_pop   = (state == S_ISSUE) & ~cmd_empty & ~flush;
  assign cmd_head  = cmd_mem[cmd_rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wp    <= '0;
      cmd_rp    <= '0;
      cmd_count <= '0;
    end else if (flush) begin
      cmd_wp    <= '0;
      cmd_rp    <= '0;
      cmd_count <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + PW'(1);
      if (cmd_pop)  cmd_rp <= cmd_rp + PW'(1);
      cmd_count <= cmd_count + CW'(cmd_push) - CW'(cmd_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {opa_stage, opb_stage, writedata[1:0]};
  end

  assign res_full  = (res_count == CW'(DEPTH));
  assign res_empty = (res_count == '0);
  assign res_push  = seq_push & ~flush;
  assign res_pop   = rd_result & ~res_empty & ~flush;
  assign res_head  = res_mem[res_rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      res_wp    <= '0;
      res_rp    <= '0;
      res_count <= '0;
    end else if (flush) begin
      res_wp    <= '0;
      res_rp    <= '0;
      res_count <= '0;
    end else begin
      if (res_push) res_wp <= res_wp + PW'(1);
      if (res_pop)  res_rp <= res_rp + PW'(1);
      res_count <= res_count + CW'(res_push) - CW'(res_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (res_push) res_mem[res_wp] <= seq_data;
  end

  // Sequencer. A flush while an operation is in flight parks in DRAIN so
  // the stale core_done (or the timeout) is absorbed without a push.
  assign tmo_expire = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign launch     = (state == S_IDLE) & (state_nx == S_ISSUE);

  always_comb begin
    state_nx = state;
    seq_push = 1'b0;
    seq_data = '0;
    to_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cmd_empty && !res_full && !flush) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        state_nx = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          seq_push = 1'b1;
          seq_data = core_result;
          state_nx = S_IDLE;
        end else if (tmo_expire) begin
          seq_push = 1'b1;
          seq_data = 32'hFFFF_FFFF;
          to_set   = 1'b1;
          state_nx = S_IDLE;
        end else if (flush) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (core_done || tmo_expire) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      core_op    <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nx;
      core_start <= launch;
      if (launch) begin
        core_a  <= cmd_head[CMD_W-1 -: OP_W];
        core_b  <= cmd_head[2 +: OP_W];
        core_op <= cmd_head[1:0];
      end
      if (state == S_ISSUE)
        tmo_cnt <= '0;
      else if ((state == S_WAIT || state == S_DRAIN) && !tmo_expire)
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Register file; setting a sticky flag wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_stage <= '0;
      opb_stage <= '0;
      irq_en    <= 1'b0;
      ovf_flag  <= 1'b0;
      unf_flag  <= 1'b0;
      to_flag   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_acc && address == A_OPA) opa_stage <= writedata[OP_W-1:0];
      if (wr_acc && address == A_OPB) opb_stage <= writedata[OP_W-1:0];
      if (wr_ctrl) irq_en <= writedata[0];
      if (wr_cmd && cmd_full)                  ovf_flag <= 1'b1;
      else if (wr_ctrl && writedata[1])        ovf_flag <= 1'b0;
      if (rd_result && res_empty && !flush)    unf_flag <= 1'b1;
      else if (wr_ctrl && writedata[1])        unf_flag <= 1'b0;
      if (to_set)                              to_flag  <= 1'b1;
      else if (wr_ctrl && writedata[1])        to_flag  <= 1'b0;
      irq <= irq_en & ~res_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_acc) begin
      case (address)
        A_RESULT: readdata <= res_empty ? 32'd0 : res_head;
        A_STATUS: readdata <= {8'd0, 8'(res_count), 8'(cmd_count),
                               to_flag, unf_flag, ovf_flag, res_full,
                               res_empty, cmd_empty, cmd_full,
                               (state != S_IDLE)};
        A_CTRL:   readdata <= {31'd0, irq_en};
        default:  readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mm_queued.sv
// Self-checking bench for fpu_mm_queued: queue-based reference model compared
// every cycle, a small core model, directed scenarios and a random phase.
module tb_fpu_mm_queued;

  localparam int OP_W  = 17;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset, chipselect, write, read;
  logic [4:0]  address;
  logic [31:0] writedata, readdata, core_result;
  logic        irq, core_start, core_done;
  logic [OP_W-1:0] core_a, core_b;
  logic [1:0]  core_op;

  fpu_mm_queued #(.INT_W(8), .FRAC_W(8), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write(write), .read(read), .writedata(writedata), .readdata(readdata),
    .irq(irq), .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_op(core_op), .core_done(core_done), .core_result(core_result));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] core_fn(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    core_fn = 32'(a) + 32'(b);
      2'd1:    core_fn = 32'(a) - 32'(b);
      2'd2:    core_fn = 32'(a) * 32'(b);
      default: core_fn = {15'd0, a} ^ {b, 15'd0};
    endcase
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed { logic [OP_W-1:0] a; logic [OP_W-1:0] b; logic [1:0] op; } cmd_t;
  cmd_t        cmd_q[$];
  logic [31:0] res_q[$];
  logic [OP_W-1:0] m_opa, m_opb, m_a, m_b;
  logic [1:0]  m_op;
  logic        m_irq_en, m_ovf, m_unf, m_to, m_irq, m_start;
  logic [31:0] m_rd;
  int          phase;   // 0 idle, 1 issue, 2 waiting, 3 draining
  int          waited;

  always @(posedge clk) begin : mdl
    logic aw, ar, fl, do_push, new_to;
    logic [31:0] pushv;
    int rsz, csz;
    if (reset) begin
      cmd_q.delete(); res_q.delete();
      m_opa = '0; m_opb = '0; m_a = '0; m_b = '0; m_op = '0;
      m_irq_en = 0; m_ovf = 0; m_unf = 0; m_to = 0; m_irq = 0; m_start = 0;
      m_rd = '0; phase = 0; waited = 0;
    end else begin
      aw = chipselect && write;
      ar = chipselect && read;
      fl = aw && address == 5'd5 && writedata[2];
      rsz = res_q.size();
      csz = cmd_q.size();
      m_irq = m_irq_en && (rsz != 0);
      if (ar) begin
        case (address)
          5'd3: m_rd = (rsz != 0) ? res_q[0] : 32'd0;
          5'd4: m_rd = {8'd0, 8'(rsz), 8'(csz), m_to, m_unf, m_ovf, rsz == DEPTH,
                        rsz == 0, csz == 0, csz == DEPTH, phase != 0};
          5'd5: m_rd = {31'd0, m_irq_en};
          default: m_rd = 32'd0;
        endcase
      end
      m_start = 0; do_push = 0; new_to = 0; pushv = '0;
      case (phase)
        0: if (csz > 0 && rsz < DEPTH && !fl) begin
             phase = 1; m_start = 1;
             m_a = cmd_q[0].a; m_b = cmd_q[0].b; m_op = cmd_q[0].op;
           end
        1: begin
             if (cmd_q.size() > 0) void'(cmd_q.pop_front());
             waited = 0;
             phase = fl ? 3 : 2;
           end
        2: begin
             waited++;
             if (core_done) begin do_push = 1; pushv = core_result; phase = 0; end
             else if (waited == TMO) begin do_push = 1; pushv = 32'hFFFF_FFFF; new_to = 1; phase = 0; end
             else if (fl) phase = 3;
           end
        default: begin
             waited++;
             if (core_done || waited == TMO) phase = 0;
           end
      endcase
      if (aw && address == 5'd5 && writedata[1]) begin m_ovf = 0; m_unf = 0; m_to = 0; end
      if (aw && address == 5'd2 && csz == DEPTH) m_ovf = 1;
      if (ar && address == 5'd3 && rsz == 0 && !fl) m_unf = 1;
      if (new_to) m_to = 1;
      if (fl) begin
        cmd_q.delete(); res_q.delete();
      end else begin
        if (ar && address == 5'd3 && rsz > 0) void'(res_q.pop_front());
        if (do_push) res_q.push_back(pushv);
        if (aw && address == 5'd2 && csz < DEPTH)
          cmd_q.push_back('{a: m_opa, b: m_opb, op: writedata[1:0]});
      end
      if (aw && address == 5'd5) m_irq_en = writedata[0];
      if (aw && address == 5'd0) m_opa = writedata[OP_W-1:0];
      if (aw && address == 5'd1) m_opb = writedata[OP_W-1:0];
    end
  end

  // ---------------- per-cycle compare + core model ----------------
  bit core_hold = 0, core_mute = 0, rnd_lat = 0;
  bit pend = 0;
  int cnt = 0;
  int start_cnt = 0;
  logic [OP_W-1:0] pa, pb;
  logic [1:0] pop_;

  always @(negedge clk) begin
    if (chk_en) begin
      check("readdata",   readdata,          m_rd);
      check("irq",        32'(irq),          32'(m_irq));
      check("core_start", 32'(core_start),   32'(m_start));
      check("core_a",     32'(core_a),       32'(m_a));
      check("core_b",     32'(core_b),       32'(m_b));
      check("core_op",    32'(core_op),      32'(m_op));
    end
    if (core_start) start_cnt++;
    core_done = 1'b0;
    core_result = $urandom();
    if (core_start) begin
      if (!(core_mute || (rnd_lat && $urandom_range(0, 15) == 0))) begin
        pend = 1; pa = core_a; pb = core_b; pop_ = core_op;
        cnt = rnd_lat ? int'($urandom_range(1, 20)) : 5;
      end
    end else if (pend) begin
      if (cnt > 1) cnt--;
      else if (!core_hold) begin
        core_done = 1'b1;
        core_result = core_fn(pa, pb, pop_);
        pend = 0;
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    chipselect = 1; write = 1; address = a; writedata = d;
    @(negedge clk); #1;
    chipselect = 0; write = 0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk); #1;
    chipselect = 1; read = 1; address = a;
    @(negedge clk);
    d = readdata;
    #1;
    chipselect = 0; read = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st, d;
    int s0;
    bit got;
    reset = 1; chipselect = 0; write = 0; read = 0; address = '0; writedata = '0;
    core_done = 0; core_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    #1 reset = 0;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_core_a", 32'(core_a), 32'd0);

    // single operation
    bus_wr(5'd0, 32'h0_0380);
    bus_wr(5'd1, 32'h0_0140);
    bus_wr(5'd2, 32'd0);
    @(negedge clk);
    check("single_start", 32'(core_start), 32'd1);
    check("single_a", 32'(core_a), 32'h0380);
    check("single_b", 32'(core_b), 32'h0140);
    idle(8);
    bus_rd(5'd4, st);
    check("single_rescount", st & 32'h00FF_0008, 32'h0001_0000);
    bus_rd(5'd3, d);
    check("single_result", d, 32'h0000_04C0);
    bus_rd(5'd4, st);
    check("single_empty", st & 32'h00FF_0008, 32'h0000_0008);

    // back-pressure and overflow
    for (int i = 0; i < 4; i++) begin
      bus_wr(5'd0, 32'h100 * i + 1);
      bus_wr(5'd2, 32'(i));
      idle(10);
    end
    bus_rd(5'd4, st);
    check("bp_full", st & 32'h00FF_0010, 32'h0004_0010);
    s0 = start_cnt;
    bus_wr(5'd2, 32'd0);
    bus_wr(5'd2, 32'd1);
    idle(20);
    check("bp_nostart", 32'(start_cnt), 32'(s0));
    bus_wr(5'd2, 32'd2);
    bus_wr(5'd2, 32'd3);
    bus_wr(5'd2, 32'd0);
    bus_rd(5'd4, st);
    check("ovf_set", st & 32'h0000_FF22, 32'h0000_0422);
    bus_rd(5'd3, d);
    check("bp_first", d, 32'h0000_0141);
    idle(20);
    check("bp_one_issue", 32'(start_cnt), 32'(s0 + 1));
    repeat (10) begin
      bus_rd(5'd3, d);
      idle(10);
    end
    bus_rd(5'd4, st);
    check("drained", st & 32'h00FF_FF01, 32'd0);
    bus_wr(5'd5, 32'h2);
    bus_rd(5'd4, st);
    check("flags_clr", st & 32'h0000_00E0, 32'd0);

    // timeout
    core_mute = 1;
    bus_wr(5'd2, 32'd3);
    idle(25);
    bus_rd(5'd4, st);
    check("timeout_status", st & 32'h00FF_0081, 32'h0001_0080);
    bus_rd(5'd3, d);
    check("timeout_result", d, 32'hFFFF_FFFF);
    core_mute = 0;
    bus_wr(5'd5, 32'h2);

    // flush while waiting
    core_hold = 1;
    bus_wr(5'd2, 32'd0);
    idle(3);
    bus_wr(5'd5, 32'h4);
    bus_rd(5'd4, st);
    check("flush_drain", st & 32'h00FF_FF01, 32'h0000_0001);
    core_hold = 0;
    idle(6);
    bus_rd(5'd4, st);
    check("flush_discard", st & 32'h00FF_FF01, 32'd0);

    // empty read
    bus_rd(5'd3, d);
    check("empty_read", d, 32'd0);
    bus_rd(5'd4, st);
    check("unf_set", st & 32'h40, 32'h40);
    bus_wr(5'd5, 32'h2);

    // interrupt
    bus_wr(5'd5, 32'h1);
    bus_wr(5'd2, 32'd0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irq) begin got = 1; break; end
    end
    check("irq_set", 32'(got), 32'd1);
    bus_rd(5'd3, d);
    idle(2);
    check("irq_clr", 32'(irq), 32'd0);

    // reset during wait
    core_hold = 1;
    bus_wr(5'd2, 32'd2);
    idle(3);
    #1 reset = 1;
    @(negedge clk);
    check("rstw_start", 32'(core_start), 32'd0);
    check("rstw_a", 32'(core_a), 32'd0);
    check("rstw_rd", readdata, 32'd0);
    check("rstw_irq", 32'(irq), 32'd0);
    #1 reset = 0;
    core_hold = 0;
    idle(6);
    bus_rd(5'd4, st);
    check("rstw_late_done", st & 32'h00FF_FF01, 32'd0);

    // random traffic against the model
    rnd_lat = 1;
    for (int c = 0; c < 1500; c++) begin
      int k;
      @(negedge clk); #1;
      k = $urandom_range(0, 15);
      chipselect = ($urandom_range(0, 7) != 0);
      read = 0; write = 0;
      writedata = $urandom();
      case (k)
        0, 1, 2, 3: begin write = 1; address = 5'd2; end
        4:          begin write = 1; address = 5'd0; end
        5:          begin write = 1; address = 5'd1; end
        6, 7, 8, 9: begin read = 1; address = 5'd3; end
        10:         begin read = 1; address = 5'd4; end
        11: begin
          write = 1; address = 5'd5;
          writedata[2] = ($urandom_range(0, 5) == 0);
        end
        12:         begin read = 1; address = 5'd5; end
        13: begin
          address = 5'($urandom_range(6, 31));
          read = $urandom_range(0, 1); write = ~read;
        end
        default: chipselect = 0;
      endcase
    end
    @(negedge clk); #1;
    chipselect = 0; read = 0; write = 0;
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
